// File: rtl/inst_data_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner encoding, constants.
// Latency: none (types and constants only).
// Backpressure: n/a.
package inst_data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Which requester owns the transaction currently in flight.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int RSP_W    = 32;
   localparam int STREAK_W = 4;

   // Response data returned to the data stage for stores.
   localparam logic [RSP_W-1:0] RSP_ZERO = '0;

   // Saturating increment of the data-streak counter.
   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                      input logic [STREAK_W-1:0] max);
      return (cur >= max) ? max : cur + 1'b1;
   endfunction

endpackage

// File: rtl/inst_data_mem_arbiter_if.sv
// Bundle of fetch, data and memory channels around the arbiter.
// Latency: none (wiring only).
// Backpressure: valid/ready on requests and on the fetch response; memory response is a pulse.
// Ports: master = arbiter view (takes requests, drives memory); slave = surrounding stages + memory.
interface inst_data_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch stage
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic              if_rsp_ready;
   logic [ADDR_W-1:0] if_rsp_addr;
   logic [DATA_W-1:0] if_rsp_data;
   logic              if_flush;
   // data stage
   logic              dm_req_valid;
   logic              dm_req_ready;
   logic [3:0]        dm_wen;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_rsp_valid;
   logic [DATA_W-1:0] dm_rsp_data;
   // shared memory
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [3:0]        mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req_valid, if_addr, if_rsp_ready, if_flush,
      input  dm_req_valid, dm_wen, dm_addr, dm_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rdata,
      output if_req_ready, if_rsp_valid, if_rsp_addr, if_rsp_data,
      output dm_req_ready, dm_rsp_valid, dm_rsp_data,
      output mem_req_valid, mem_wen, mem_addr, mem_wdata
   );

   modport slave (
      output if_req_valid, if_addr, if_rsp_ready, if_flush,
      output dm_req_valid, dm_wen, dm_addr, dm_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rsp_addr, if_rsp_data,
      input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
      input  mem_req_valid, mem_wen, mem_addr, mem_wdata
   );

endinterface

// File: rtl/inst_data_mem_arbiter_pick.sv
// Grant selection between fetch and data requesters with a data-streak fairness limit.
// Latency: purely combinational.
// Backpressure: none; the caller only acts on the grant when it is idle.
// Ports: if_valid/dm_valid request flags, streak = consecutive data grants seen while fetch waited,
//        grant_vld = someone is requesting, grant_own = winning requester.
module mem_arb_pick
   import inst_data_mem_arbiter_pkg::*;
#(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                if_valid,
   input  logic                dm_valid,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_vld,
   output owner_t              grant_own
);

   logic streak_full;

   always_comb begin
      streak_full = (streak == STREAK_W'(MAX_DATA_STREAK));
      grant_vld   = if_valid | dm_valid;
      // Data is preferred; fetch only wins when data is absent or has had its full streak.
      if (dm_valid && !(if_valid && streak_full)) begin
         grant_own = OWN_DM;
      end else begin
         grant_own = OWN_IF;
      end
   end

endmodule

// File: rtl/inst_data_mem_arbiter.sv
// Shares one single-ported memory channel between instruction fetch and data access, one transaction at a time.
// Latency: request handshake N -> mem_req_valid N+1; memory response M -> if/dm response M+1.
// Backpressure: requesters see ready only when idle; mem_req held until mem_req_ready; fetch response held until if_rsp_ready.
// Ports: clk, reset (sync, active-high), bus (fetch, data and memory channels, master view).
module inst_data_mem_arbiter
   import inst_data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   inst_data_mem_arbiter_if.master bus
);

   state_t              state, state_nx;
   owner_t              owner, grant_own;
   logic                grant_vld;
   logic                grant_fire;
   logic                rsp_take;
   logic                drop_fetch;
   logic [STREAK_W-1:0] streak;
   logic                discard;

   logic [ADDR_W-1:0]   req_addr;
   logic [3:0]          req_wen;
   logic [DATA_W-1:0]   req_wdata;
   logic [ADDR_W-1:0]   rsp_addr;
   logic [DATA_W-1:0]   rsp_data;
   logic                dm_rsp_valid_q;
   logic [DATA_W-1:0]   dm_rsp_data_q;

   mem_arb_pick #(
      .MAX_DATA_STREAK(MAX_DATA_STREAK)
   ) u_pick (
      .if_valid  (bus.if_req_valid),
      .dm_valid  (bus.dm_req_valid),
      .streak    (streak),
      .grant_vld (grant_vld),
      .grant_own (grant_own)
   );

   always_comb begin
      state_nx          = state;
      grant_fire        = 1'b0;
      rsp_take          = 1'b0;
      // A flush arriving together with the response still kills it.
      drop_fetch        = discard | bus.if_flush;
      bus.if_req_ready  = 1'b0;
      bus.dm_req_ready  = 1'b0;
      bus.mem_req_valid = 1'b0;
      bus.if_rsp_valid  = 1'b0;

      case (state)
         IDLE: begin
            if (grant_vld && !reset) begin
               grant_fire       = 1'b1;
               state_nx         = ISSUE;
               bus.if_req_ready = (grant_own == OWN_IF);
               bus.dm_req_ready = (grant_own == OWN_DM);
            end
         end
         ISSUE: begin
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) begin
               // Zero-wait memory may answer in the same cycle it accepts.
               if (bus.mem_rsp_valid) rsp_take = 1'b1;
               else                   state_nx = WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_rsp_valid) rsp_take = 1'b1;
         end
         HOLD: begin
            bus.if_rsp_valid = 1'b1;
            if (bus.if_rsp_ready || bus.if_flush) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if (rsp_take) begin
         state_nx = (owner == OWN_IF && !drop_fetch) ? HOLD : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         owner          <= OWN_IF;
         streak         <= '0;
         discard        <= 1'b0;
         req_addr       <= '0;
         req_wen        <= '0;
         req_wdata      <= '0;
         rsp_addr       <= '0;
         rsp_data       <= '0;
         dm_rsp_valid_q <= 1'b0;
         dm_rsp_data_q  <= '0;
      end else begin
         state          <= state_nx;
         dm_rsp_valid_q <= 1'b0;

         // Streak only measures how long a waiting fetch has been passed over.
         if (!bus.if_req_valid) begin
            streak <= '0;
         end else if (grant_fire) begin
            streak <= (grant_own == OWN_IF) ? '0
                      : streak_inc(streak, STREAK_W'(MAX_DATA_STREAK));
         end

         if (grant_fire) begin
            owner   <= grant_own;
            discard <= 1'b0;
            if (grant_own == OWN_DM) begin
               req_addr  <= bus.dm_addr;
               req_wen   <= bus.dm_wen;
               req_wdata <= bus.dm_wdata;
            end else begin
               req_addr  <= bus.if_addr;
               req_wen   <= '0;
               req_wdata <= '0;
            end
         end else if ((state == ISSUE || state == WAIT) && owner == OWN_IF && bus.if_flush) begin
            // The memory access must still finish; only its result is thrown away.
            discard <= 1'b1;
         end

         if (rsp_take) begin
            if (owner == OWN_DM) begin
               dm_rsp_valid_q <= 1'b1;
               dm_rsp_data_q  <= (req_wen == 4'd0) ? bus.mem_rdata : DATA_W'(RSP_ZERO);
            end else if (!drop_fetch) begin
               rsp_addr <= req_addr;
               rsp_data <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_wen      = req_wen;
   assign bus.mem_addr     = req_addr;
   assign bus.mem_wdata    = req_wdata;
   assign bus.if_rsp_addr  = rsp_addr;
   assign bus.if_rsp_data  = rsp_data;
   assign bus.dm_rsp_valid = dm_rsp_valid_q;
   assign bus.dm_rsp_data  = dm_rsp_data_q;

endmodule

// File: tb/tb_inst_data_mem_arbiter.sv
// Directed scoreboard bench for the instruction/data memory arbiter.
// Latency: n/a (testbench).
// Backpressure: memory model with programmable ready and response latency; fetch ready toggled per test.
module tb_inst_data_mem_arbiter;

   typedef struct {
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } if_exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;

   mem_exp_t    exp_mem[$];
   if_exp_t     exp_if[$];
   logic [31:0] exp_dm[$];

   int          if_rsp_cyc;
   logic        prev_dm_vld;

   // memory model controls
   int          mem_lat;
   logic [31:0] mem_word;
   logic        inject_rsp;
   int          pend_cnt;
   logic [31:0] pend_data;

   inst_data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   inst_data_mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MAX_DATA_STREAK(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Memory: responds mem_lat cycles after the accepting cycle (0 = same cycle).
   always @(posedge clk) begin
      #1;
      bus.mem_rsp_valid = 1'b0;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = pend_data;
         end
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         if (mem_lat == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = mem_word;
         end else begin
            pend_cnt  = mem_lat;
            pend_data = mem_word;
         end
      end
      if (inject_rsp) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rdata     = 32'h0bad0bad;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a transfer.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (exp_mem.size() == 0) begin
               note_fail("mem_req_unexpected");
            end else begin
               mem_exp_t m;
               m = exp_mem.pop_front();
               chk("mem_wen", {28'h0, bus.mem_wen}, {28'h0, m.wen});
               chk("mem_addr", bus.mem_addr, m.addr);
               chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
         end
         if (bus.if_rsp_valid && bus.if_rsp_ready) begin
            if (exp_if.size() == 0) begin
               note_fail("if_rsp_unexpected");
            end else begin
               if_exp_t e;
               e = exp_if.pop_front();
               chk("if_rsp_addr", bus.if_rsp_addr, e.addr);
               chk("if_rsp_data", bus.if_rsp_data, e.data);
               if_rsp_cyc = cyc;
            end
         end
         if (bus.dm_rsp_valid) begin
            if (prev_dm_vld) note_fail("dm_rsp_pulse_width");
            if (exp_dm.size() == 0) begin
               note_fail("dm_rsp_unexpected");
            end else begin
               chk("dm_rsp_data", bus.dm_rsp_data, exp_dm.pop_front());
            end
         end
      end
      prev_dm_vld = bus.dm_rsp_valid;
   end

   // Present one request and wait (bounded) for its handshake; hs = handshake cycle.
   task automatic request(input bit is_dm, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit flush_with, output int hs);
      int  n;
      logic rdy;
      n  = 0;
      hs = -1;
      @(negedge clk);
      if (is_dm) begin
         bus.dm_req_valid = 1'b1;
         bus.dm_wen       = wen;
         bus.dm_addr      = addr;
         bus.dm_wdata     = wdata;
      end else begin
         bus.if_req_valid = 1'b1;
         bus.if_addr      = addr;
      end
      bus.if_flush = flush_with;
      #1;
      rdy = is_dm ? bus.dm_req_ready : bus.if_req_ready;
      while (!rdy && n < 100) begin
         @(negedge clk);
         #1;
         rdy = is_dm ? bus.dm_req_ready : bus.if_req_ready;
         n++;
      end
      if (rdy) hs = cyc;
      else     note_fail("req_handshake_timeout");
      @(negedge clk);
      bus.if_req_valid = 1'b0;
      bus.dm_req_valid = 1'b0;
      bus.if_flush     = 1'b0;
   endtask

   initial begin
      int hs;
      int n;
      int grants;
      checks       = 0;
      failures     = 0;
      if_rsp_cyc   = -1;
      prev_dm_vld  = 1'b0;
      mem_lat      = 0;
      mem_word     = 32'h0;
      inject_rsp   = 1'b0;
      pend_cnt     = 0;
      pend_data    = 32'h0;
      reset        = 1'b1;
      bus.if_req_valid  = 1'b0;
      bus.if_addr       = 32'h0;
      bus.if_rsp_ready  = 1'b1;
      bus.if_flush      = 1'b0;
      bus.dm_req_valid  = 1'b0;
      bus.dm_wen        = 4'h0;
      bus.dm_addr       = 32'h0;
      bus.dm_wdata      = 32'h0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_if_req_ready", {31'h0, bus.if_req_ready}, 32'h0);
      chk("rst_dm_req_ready", {31'h0, bus.dm_req_ready}, 32'h0);
      chk("rst_if_rsp_valid", {31'h0, bus.if_rsp_valid}, 32'h0);
      chk("rst_dm_rsp_valid", {31'h0, bus.dm_rsp_valid}, 32'h0);
      chk("rst_mem_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
      chk("rst_mem_wen", {28'h0, bus.mem_wen}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_if_rsp_addr", bus.if_rsp_addr, 32'h0);
      chk("rst_if_rsp_data", bus.if_rsp_data, 32'h0);
      chk("rst_dm_rsp_data", bus.dm_rsp_data, 32'h0);
      reset = 1'b0;

      // Fetch only, zero-wait memory: response two cycles after the handshake cycle
      mem_word = 32'h24080001;
      exp_mem.push_back('{4'h0, 32'hbfc00000, 32'h0});
      exp_if.push_back('{32'hbfc00000, 32'h24080001});
      request(1'b0, 4'h0, 32'hbfc00000, 32'h0, 1'b0, hs);
      repeat (4) @(negedge clk);
      chk("fetch_rsp_cycle", if_rsp_cyc, hs + 2);

      // Store: memory sees the store fields, response data is zero
      mem_word = 32'h12345678;
      exp_mem.push_back('{4'hF, 32'h80001000, 32'hdeadbeef});
      exp_dm.push_back(32'h0);
      request(1'b1, 4'hF, 32'h80001000, 32'hdeadbeef, 1'b0, hs);
      repeat (6) @(negedge clk);

      // Load with 2-cycle memory latency; a flush during WAIT must not affect data
      mem_lat  = 2;
      mem_word = 32'hcafef00d;
      exp_mem.push_back('{4'h0, 32'h80002004, 32'h0});
      exp_dm.push_back(32'hcafef00d);
      request(1'b1, 4'h0, 32'h80002004, 32'h0, 1'b0, hs);
      @(negedge clk);
      bus.if_flush = 1'b1;
      @(negedge clk);
      bus.if_flush = 1'b0;
      repeat (6) @(negedge clk);

      // Flush in WAIT of a fetch: response dropped, next fetch normal
      mem_lat  = 3;
      mem_word = 32'h3c1dbfc0;
      exp_mem.push_back('{4'h0, 32'hbfc00010, 32'h0});
      request(1'b0, 4'h0, 32'hbfc00010, 32'h0, 1'b0, hs);
      @(negedge clk);
      bus.if_flush = 1'b1;
      @(negedge clk);
      bus.if_flush = 1'b0;
      repeat (8) @(negedge clk);
      mem_lat  = 0;
      mem_word = 32'h27bd0010;
      exp_mem.push_back('{4'h0, 32'hbfc00100, 32'h0});
      exp_if.push_back('{32'hbfc00100, 32'h27bd0010});
      request(1'b0, 4'h0, 32'hbfc00100, 32'h0, 1'b0, hs);
      repeat (5) @(negedge clk);

      // Both held: grant order DM, DM, DM, DM, IF, DM
      mem_word = 32'h0000abcd;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin
            exp_mem.push_back('{4'h0, 32'hbfc00200, 32'h0});
            exp_if.push_back('{32'hbfc00200, 32'h0000abcd});
         end else begin
            exp_mem.push_back('{4'h0, 32'h80000040, 32'h0});
            exp_dm.push_back(32'h0000abcd);
         end
      end
      @(negedge clk);
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'hbfc00200;
      bus.dm_req_valid = 1'b1;
      bus.dm_wen       = 4'h0;
      bus.dm_addr      = 32'h80000040;
      bus.dm_wdata     = 32'h0;
      grants = 0;
      n      = 0;
      while (grants < 6 && n < 200) begin
         #1;
         if (bus.if_req_ready || bus.dm_req_ready) grants++;
         @(negedge clk);
         n++;
      end
      if (grants < 6) note_fail("arb_grant_timeout");
      bus.if_req_valid = 1'b0;
      bus.dm_req_valid = 1'b0;
      repeat (6) @(negedge clk);

      // HOLD with fetch stalled: outputs stable, flush on third cycle clears valid
      bus.if_rsp_ready = 1'b0;
      mem_word = 32'h8c080004;
      exp_mem.push_back('{4'h0, 32'hbfc00300, 32'h0});
      request(1'b0, 4'h0, 32'hbfc00300, 32'h0, 1'b0, hs);
      n = 0;
      while (!bus.if_rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) @(negedge clk);
         chk("hold_if_rsp_valid", {31'h0, bus.if_rsp_valid}, 32'h1);
         chk("hold_if_rsp_addr", bus.if_rsp_addr, 32'hbfc00300);
         chk("hold_if_rsp_data", bus.if_rsp_data, 32'h8c080004);
      end
      bus.if_flush = 1'b1;
      @(negedge clk);
      bus.if_flush = 1'b0;
      chk("hold_flush_valid_low", {31'h0, bus.if_rsp_valid}, 32'h0);
      bus.if_rsp_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Flush in IDLE with a same-cycle fetch: that fetch is kept
      mem_word = 32'h24020005;
      exp_mem.push_back('{4'h0, 32'hbfc00500, 32'h0});
      exp_if.push_back('{32'hbfc00500, 32'h24020005});
      request(1'b0, 4'h0, 32'hbfc00500, 32'h0, 1'b1, hs);
      repeat (5) @(negedge clk);

      // Reset during ISSUE: request dropped, late response ignored
      bus.mem_req_ready = 1'b0;
      request(1'b0, 4'h0, 32'hbfc00400, 32'h0, 1'b0, hs);
      chk("issue_mem_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
      chk("issue_mem_addr", bus.mem_addr, 32'hbfc00400);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_issue_mem_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
      chk("rst_issue_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_issue_if_rsp_valid", {31'h0, bus.if_rsp_valid}, 32'h0);
      chk("rst_issue_if_req_ready", {31'h0, bus.if_req_ready}, 32'h0);
      reset = 1'b0;
      bus.mem_req_ready = 1'b1;
      inject_rsp = 1'b1;
      @(negedge clk);
      inject_rsp = 1'b0;
      repeat (5) @(negedge clk);
      chk("late_rsp_if_rsp_valid", {31'h0, bus.if_rsp_valid}, 32'h0);
      mem_word = 32'h03e00008;
      exp_mem.push_back('{4'h0, 32'hbfc00600, 32'h0});
      exp_if.push_back('{32'hbfc00600, 32'h03e00008});
      request(1'b0, 4'h0, 32'hbfc00600, 32'h0, 1'b0, hs);
      repeat (5) @(negedge clk);

      chk("exp_mem_left", exp_mem.size(), 32'h0);
      chk("exp_if_left", exp_if.size(), 32'h0);
      chk("exp_dm_left", exp_dm.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
